debug_loader: RTL and testbench

//  UART command front end upstream of the pipelined datapath. Takes a received byte stream,

---
 rtl/debug_loader_if.sv | 40 ++++
 rtl/debug_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_debug_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : debug_loader_if
// Description : Bundles the UART RX/TX handshake, the IMEM write port and the
//               datapath control/status signals seen by debug_loader.
//               slave  : debug_loader side (consumes RX/status, drives TX,
//                        IMEM and CPU control)
//               master : surrounding system side (UART pair, datapath)
// Revision    : 1.0 - initial release
// ============================================================================
interface debug_loader_if #(
    parameter int NBITS = 32,
    parameter int ABITS = 10
);
    logic [7:0]       i_rx_data;
    logic             i_rx_valid;
    logic             i_tx_busy;
    logic [7:0]       o_tx_data;
    logic             o_tx_start;
    logic             o_imem_we;
    logic [ABITS-1:0] o_imem_addr;
    logic [NBITS-1:0] o_imem_wdata;
    logic             o_cpu_en;
    logic             o_cpu_rst;
    logic [NBITS-1:0] i_pc;
    logic             i_halt;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_pc, i_halt,
        output o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata,
               o_cpu_en, o_cpu_rst
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_busy, i_pc, i_halt,
        input  o_tx_data, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata,
               o_cpu_en, o_cpu_rst
    );
endinterface
`default_nettype wire

// File: rtl/debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : debug_loader
// Description : UART command front end for the pipelined datapath.
//               'L' loads N 32-bit words (count MSB first, data MSB first)
//               into IMEM, 'R' runs until halt, 'S' single-steps, 'X'
//               pulses the datapath reset. The PC is returned MSB first
//               after every step/halt; load and reset reply with one byte.
// Ports       : i_clk  - system clock, rising edge
//               i_rst  - asynchronous reset, active-low
//               bus    - debug_loader_if.slave (RX byte stream, TX request,
//                        IMEM write port, cpu_en/cpu_rst, pc/halt status)
// Revision    : 1.0 - initial release
// ============================================================================
module debug_loader #(
    parameter int NBITS    = 32,
    parameter int MEM_SIZE = 1024,
    parameter int ABITS    = 10
) (
    input  wire logic     i_clk,
    input  wire logic     i_rst,
    debug_loader_if.slave bus
);

    localparam int         NB         = NBITS / 8;
    localparam logic [7:0] C_CMD_LOAD = 8'h4C;
    localparam logic [7:0] C_CMD_RUN  = 8'h52;
    localparam logic [7:0] C_CMD_STEP = 8'h53;
    localparam logic [7:0] C_CMD_XRST = 8'h58;
    // Single-byte replies are left-aligned so the normal MSB-first TX path sends them.
    localparam logic [NBITS-1:0] C_REPLY_LOAD = NBITS'(C_CMD_LOAD) << (NBITS - 8);
    localparam logic [NBITS-1:0] C_REPLY_XRST = NBITS'(C_CMD_XRST) << (NBITS - 8);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_CNTH = 4'd1,
        S_LD_CNTL = 4'd2,
        S_LD_DATA = 4'd3,
        S_LD_END  = 4'd4,
        S_RUN     = 4'd5,
        S_STEP    = 4'd6,
        S_TX_SEND = 4'd7,
        S_TX_GAP  = 4'd8,
        S_TX_WAIT = 4'd9,
        S_CPURST  = 4'd10
    } state_t;

    state_t           r_state;
    logic [15:0]      r_word_total;
    logic [15:0]      r_word_cnt;
    logic [7:0]       r_byte_cnt;
    logic [7:0]       r_tx_left;
    logic [NBITS-1:0] r_shift;
    logic [NBITS-1:0] r_tx_buf;
    logic             r_step_done;
    logic             r_en_arm;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_imem_we;
    logic [ABITS-1:0] r_imem_addr;
    logic [NBITS-1:0] r_imem_wdata;
    logic             r_cpu_rst;

    logic [NBITS-1:0] w_word;
    logic             w_in_range;
    logic             w_last_word;

    // Word as it will look once the incoming byte is shifted in.
    always_comb begin
        w_word      = r_shift << 8;
        w_word[7:0] = bus.i_rx_data;
    end

    assign w_in_range  = ({16'd0, r_word_cnt} < 32'(MEM_SIZE));
    assign w_last_word = ((r_word_cnt + 16'd1) == r_word_total);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_word_total <= '0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_tx_left    <= '0;
            r_shift      <= '0;
            r_tx_buf     <= '0;
            r_step_done  <= 1'b0;
            r_en_arm     <= 1'b0;
            r_tx_data    <= '0;
            r_tx_start   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_imem_we  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_rx_valid) begin
                        case (bus.i_rx_data)
                            C_CMD_LOAD: begin
                                r_state   <= S_LD_CNTH;
                                r_cpu_rst <= 1'b1;
                            end
                            C_CMD_RUN: begin
                                r_state  <= S_RUN;
                                r_en_arm <= 1'b1;
                            end
                            C_CMD_STEP: begin
                                r_state     <= S_STEP;
                                r_en_arm    <= 1'b1;
                                r_step_done <= 1'b0;
                            end
                            C_CMD_XRST: begin
                                r_state   <= S_CPURST;
                                r_cpu_rst <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_LD_CNTH: begin
                    if (bus.i_rx_valid) begin
                        r_word_total[15:8] <= bus.i_rx_data;
                        r_state            <= S_LD_CNTL;
                    end
                end
                S_LD_CNTL: begin
                    if (bus.i_rx_valid) begin
                        r_word_total[7:0] <= bus.i_rx_data;
                        r_word_cnt        <= '0;
                        r_byte_cnt        <= '0;
                        if ({r_word_total[15:8], bus.i_rx_data} == 16'd0) begin
                            r_state <= S_LD_END;
                        end else begin
                            r_state <= S_LD_DATA;
                        end
                    end
                end
                S_LD_DATA: begin
                    if (bus.i_rx_valid) begin
                        r_shift <= w_word;
                        if (r_byte_cnt == 8'(NB - 1)) begin
                            r_byte_cnt <= '0;
                            // Words beyond the memory are consumed but dropped; no wrap.
                            if (w_in_range) begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= ABITS'(r_word_cnt);
                                r_imem_wdata <= w_word;
                            end
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (w_last_word) begin
                                r_state <= S_LD_END;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 8'd1;
                        end
                    end
                end
                S_LD_END: begin
                    r_cpu_rst <= 1'b0;
                    r_tx_buf  <= C_REPLY_LOAD;
                    r_tx_left <= 8'd1;
                    r_state   <= S_TX_SEND;
                end
                S_RUN: begin
                    if (bus.i_halt) begin
                        r_en_arm  <= 1'b0;
                        r_tx_buf  <= bus.i_pc;
                        r_tx_left <= 8'(NB);
                        r_state   <= S_TX_SEND;
                    end
                end
                S_STEP: begin
                    // First cycle carries the enable; the PC is sampled one cycle
                    // later so it reflects the step just taken.
                    if (!r_step_done) begin
                        r_en_arm    <= 1'b0;
                        r_step_done <= 1'b1;
                    end else begin
                        r_tx_buf  <= bus.i_pc;
                        r_tx_left <= 8'(NB);
                        r_state   <= S_TX_SEND;
                    end
                end
                S_CPURST: begin
                    r_cpu_rst <= 1'b0;
                    r_tx_buf  <= C_REPLY_XRST;
                    r_tx_left <= 8'd1;
                    r_state   <= S_TX_SEND;
                end
                S_TX_SEND: begin
                    if (!bus.i_tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= r_tx_buf[NBITS-1 -: 8];
                        r_tx_buf   <= r_tx_buf << 8;
                        r_tx_left  <= r_tx_left - 8'd1;
                        r_state    <= S_TX_GAP;
                    end
                end
                S_TX_GAP: begin
                    // The UART needs a cycle to raise busy after a start request.
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (!bus.i_tx_busy) begin
                        r_state <= (r_tx_left == 8'd0) ? S_IDLE : S_TX_SEND;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Enable drops in the very cycle halt is seen, hence the combinational gate.
    assign bus.o_cpu_en     = r_en_arm & ~bus.i_halt;
    assign bus.o_cpu_rst    = r_cpu_rst;
    assign bus.o_tx_data    = r_tx_data;
    assign bus.o_tx_start   = r_tx_start;
    assign bus.o_imem_we    = r_imem_we;
    assign bus.o_imem_addr  = r_imem_addr;
    assign bus.o_imem_wdata = r_imem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_debug_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_loader
// Description : Self-checking bench for debug_loader (MEM_SIZE=4 so the
//               overflow case is reachable). Expected TX bytes and IMEM
//               writes are queued when stimulus is driven and compared as
//               the DUT produces them; run/step/reset commands are table
//               driven, load/abort/noise cases are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_loader;

    localparam int NBITS    = 32;
    localparam int MEM_SIZE = 4;
    localparam int ABITS    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_loader_if #(.NBITS(NBITS), .ABITS(ABITS)) bus ();

    debug_loader #(
        .NBITS   (NBITS),
        .MEM_SIZE(MEM_SIZE),
        .ABITS   (ABITS)
    ) u_dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int tx_cnt = 0;
    int busy_cnt = 0;
    logic ext_busy = 1'b0;
    logic prev_start = 1'b0;
    logic [7:0]             exp_tx[$];
    logic [ABITS+NBITS-1:0] exp_wr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor + scoreboard + UART TX model, all on the falling edge.
    always @(negedge clk) begin
        if (bus.o_cpu_en)  en_cnt++;
        if (bus.o_cpu_rst) rst_cnt++;
        chk("en_rst_exclusive", 64'(bus.o_cpu_en & bus.o_cpu_rst), 64'd0);
        if (bus.o_tx_start) begin
            tx_cnt++;
            chk("tx_start_while_busy", 64'(bus.i_tx_busy), 64'd0);
            chk("tx_start_back_to_back", 64'(prev_start), 64'd0);
            if (exp_tx.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected none", bus.o_tx_data);
            end else begin
                chk("tx_byte", 64'(bus.o_tx_data), 64'(exp_tx.pop_front()));
            end
        end
        prev_start = bus.o_tx_start;
        if (bus.o_imem_we) begin
            chk("we_under_cpu_rst", 64'(bus.o_cpu_rst), 64'd1);
            if (exp_wr.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL imem_unexpected: got addr %0d data 0x%0h, expected none",
                         bus.o_imem_addr, bus.o_imem_wdata);
            end else begin
                chk("imem_write", 64'({bus.o_imem_addr, bus.o_imem_wdata}), 64'(exp_wr.pop_front()));
            end
        end
        if (bus.o_tx_start) busy_cnt = 6;
        else if (busy_cnt > 0) busy_cnt--;
        bus.i_tx_busy = (busy_cnt != 0) | ext_busy;
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #2;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #2;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_burst(input logic [7:0] bs[$]);
        foreach (bs[i]) begin
            @(posedge clk); #2;
            bus.i_rx_data  = bs[i];
            bus.i_rx_valid = 1'b1;
        end
        @(posedge clk); #2;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_tx.size() != 0 || bus.i_tx_busy) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #2;
        chk("tx_drain", 64'(exp_tx.size()), 64'd0);
    endtask

    // cpu_rst spans the 'L' byte through LD_END: nb cycles when bytes are
    // back to back, 2*nb-1 when spaced one idle cycle apart.
    task automatic do_load(input logic [31:0] words[$], input bit burst);
        logic [7:0] bs[$];
        int nb;
        int base;
        bs.push_back(8'h4C);
        bs.push_back(8'(words.size() >> 8));
        bs.push_back(8'(words.size()));
        foreach (words[k]) begin
            for (int j = 3; j >= 0; j--) bs.push_back(words[k][8*j +: 8]);
            if (k < MEM_SIZE) exp_wr.push_back({ABITS'(k), words[k]});
        end
        exp_tx.push_back(8'h4C);
        nb   = bs.size();
        base = rst_cnt;
        if (burst) send_burst(bs);
        else foreach (bs[i]) send_rx(bs[i]);
        wait_idle();
        chk("ld_cpu_rst_cycles", 64'(rst_cnt - base), 64'(burst ? nb : 2 * nb - 1));
        chk("ld_writes_drained", 64'(exp_wr.size()), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] pc;
        int          halt_after;   // -1 never, 0 already high on entry
        int          busy_hold;    // cycles the UART reports busy up front
        int          exp_en;
        int          exp_rst;
        bit          is_pc;        // reply is the PC, else the command byte
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : main
        int b_en;
        int b_rst;
        int b_tx;
        logic [31:0] w2[$];
        logic [31:0] w5[$];
        logic [31:0] w0[$];
        logic [31:0] wb[$];
        logic [31:0] wa[$];

        vecs[0] = '{8'h53, 32'h0000_0004, -1,  0,  1, 0, 1'b1};
        vecs[1] = '{8'h52, 32'h0000_0028, 20,  0, 20, 0, 1'b1};
        vecs[2] = '{8'h52, 32'h0000_0028,  0,  0,  0, 0, 1'b1};
        vecs[3] = '{8'h53, 32'h1234_ABCD,  0,  0,  0, 0, 1'b1};
        vecs[4] = '{8'h52, 32'hDEAD_BEEF,  3,  0,  3, 0, 1'b1};
        vecs[5] = '{8'h58, 32'h0000_0000, -1, 10,  0, 1, 1'b0};
        vecs[6] = '{8'h53, 32'h8000_0001, -1, 12,  1, 0, 1'b1};

        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_pc       = '0;
        bus.i_halt     = 1'b0;

        // Reset held for 3 cycles, outputs quiet during and after.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_cpu_rst", 64'(bus.o_cpu_rst), 64'd0);
        chk("rst_hold_tx_start", 64'(bus.o_tx_start), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", 64'(bus.o_tx_start), 64'd0);
        chk("rst_tx_data", 64'(bus.o_tx_data), 64'd0);
        chk("rst_imem_we", 64'(bus.o_imem_we), 64'd0);
        chk("rst_imem_addr", 64'(bus.o_imem_addr), 64'd0);
        chk("rst_imem_wdata", 64'(bus.o_imem_wdata), 64'd0);
        chk("rst_cpu_en", 64'(bus.o_cpu_en), 64'd0);
        chk("rst_cpu_rst", 64'(bus.o_cpu_rst), 64'd0);

        // Unknown byte in IDLE does nothing.
        b_en = en_cnt; b_rst = rst_cnt; b_tx = tx_cnt;
        send_rx(8'h41);
        repeat (10) @(posedge clk);
        #2;
        chk("noise_en", 64'(en_cnt - b_en), 64'd0);
        chk("noise_rst", 64'(rst_cnt - b_rst), 64'd0);
        chk("noise_tx", 64'(tx_cnt - b_tx), 64'd0);

        // Two-word load with spaced bytes.
        w2 = '{32'h1234_5678, 32'h9ABC_DEF0};
        do_load(w2, 1'b0);

        // Run / step / CPU reset table.
        foreach (vecs[i]) begin
            b_en  = en_cnt;
            b_rst = rst_cnt;
            if (vecs[i].is_pc) begin
                for (int j = 3; j >= 0; j--) exp_tx.push_back(vecs[i].pc[8*j +: 8]);
            end else begin
                exp_tx.push_back(vecs[i].cmd);
            end
            bus.i_pc   = vecs[i].pc;
            bus.i_halt = (vecs[i].halt_after == 0);
            ext_busy   = (vecs[i].busy_hold > 0);
            send_rx(vecs[i].cmd);
            if (vecs[i].halt_after > 0) begin
                repeat (vecs[i].halt_after) begin
                    @(posedge clk); #2;
                end
                bus.i_halt = 1'b1;
            end
            if (vecs[i].busy_hold > 0) begin
                repeat (vecs[i].busy_hold) begin
                    @(posedge clk); #2;
                end
                ext_busy = 1'b0;
            end
            wait_idle();
            chk($sformatf("vec%0d_cpu_en_cycles", i), 64'(en_cnt - b_en), 64'(vecs[i].exp_en));
            chk($sformatf("vec%0d_cpu_rst_cycles", i), 64'(rst_cnt - b_rst), 64'(vecs[i].exp_rst));
            bus.i_halt = 1'b0;
        end

        // Back-to-back bytes: byte 0 of word 1 coincides with the word 0 write.
        wb = '{32'hA5A5_0001, 32'h5A5A_0002};
        do_load(wb, 1'b1);

        // Overflow: 5 words into a 4-word memory, then an empty load.
        w5 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        do_load(w5, 1'b0);
        w0 = {};
        do_load(w0, 1'b0);

        // 'S' arriving mid-run is dropped; enable holds 10 cycles until halt.
        b_en = en_cnt;
        bus.i_pc = 32'h0000_0ABC;
        for (int j = 3; j >= 0; j--) exp_tx.push_back(bus.i_pc[8*j +: 8]);
        send_rx(8'h52);
        repeat (3) begin
            @(posedge clk); #2;
        end
        send_rx(8'h53);
        repeat (5) begin
            @(posedge clk); #2;
        end
        bus.i_halt = 1'b1;
        wait_idle();
        bus.i_halt = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("run_drop_cpu_en_cycles", 64'(en_cnt - b_en), 64'd10);

        // Reset in the middle of LD_DATA aborts, next load restarts at addr 0.
        exp_wr.push_back({ABITS'(0), 32'h1234_5678});
        foreach (w2[i]) begin end
        send_rx(8'h4C); send_rx(8'h00); send_rx(8'h03);
        send_rx(8'h12); send_rx(8'h34); send_rx(8'h56); send_rx(8'h78);
        send_rx(8'hAA); send_rx(8'hBB);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cpu_rst", 64'(bus.o_cpu_rst), 64'd0);
        chk("abort_imem_we", 64'(bus.o_imem_we), 64'd0);
        chk("abort_imem_wdata", 64'(bus.o_imem_wdata), 64'd0);
        chk("abort_tx_start", 64'(bus.o_tx_start), 64'd0);
        chk("abort_cpu_en", 64'(bus.o_cpu_en), 64'd0);
        chk("abort_partial_writes", 64'(exp_wr.size()), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wa = '{32'hCAFE_BABE};
        do_load(wa, 1'b0);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
